rcon_gen: RTL and testbench
===========================

RCON_GEN -- requirements
Module: rcon_gen

Interface
REQ-001 Parameter WORD_W, default 32, output word width; SHALL be >= 8; the constant byte occupies bits [WORD_W-1:WORD_W-8] and all other bits are zero.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  request a new sequence; sampled only in IDLE.
REQ-005 mode  input  2  0=AES-128 (10 constants), 1=AES-192 (8), 2=AES-256 (7), 3=extended (16); latched on accepted start.
REQ-006 dir  input  1  0=forward (first constant 0x01), 1=reverse (decryption key schedule, last constant first); latched on accepted start.
REQ-007 abort  input  1  synchronous cancel of the running sequence.
REQ-008 out_ready  input  1  downstream accepts the current word.
REQ-009 out_valid  output  1  out_rcon/out_idx/out_last are valid.
REQ-010 out_rcon  output  WORD_W  round-constant word.
REQ-011 out_idx  output  4  0-based round index i of the constant (value = x^i in GF(2^8)).
REQ-012 out_last  output  1  current word is the final word of the sequence.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-015 The FSM SHALL have two states: IDLE and RUN.
REQ-016 IDLE with start=1 and abort=0 at edge T: latch mode/dir, load the seed, enter RUN; out_valid=1 with the first word from T+1.
REQ-017 Forward seed = 0x01, idx 0. Reverse seed = last constant, idx N-1: 0x36 (idx 9), 0x80 (idx 7), 0x40 (idx 6), 0x2f (idx 15) for modes 0..3.
REQ-018 A transfer SHALL occur on a rising edge where out_valid & out_ready; throughput is one word per cycle.
REQ-019 Forward step: b' = (b<<1) ^ (b[7] ? 0x1b : 0x00), idx+1. Reverse step: b' = b[0] ? ((b^0x1b)>>1)|0x80 : b>>1, idx-1.
REQ-020 While out_valid & !out_ready, all outputs SHALL hold stable.
REQ-021 out_last = 1 when idx = N-1 (forward) or idx = 0 (reverse).
REQ-022 A transfer with out_last=1 SHALL return the FSM to IDLE: out_valid=0, out_rcon=0, out_idx=0, out_last=0, busy=0; done=1 for exactly that next cycle.
REQ-023 start while in RUN, including the cycle of the final transfer, SHALL be ignored.
REQ-024 abort=1 SHALL force IDLE at the next edge from any state; abort has priority over start and over a concurrent transfer; no done pulse is produced.
REQ-025 The generated byte sequence for mode 3 forward SHALL be 01 02 04 08 10 20 40 80 1b 36 6c d8 ab 4d 9a 2f.
REQ-026 Changes to mode/dir during RUN SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE with out_valid=0, out_rcon=0, out_idx=0, out_last=0, busy=0, done=0, regardless of clk.
REQ-028 Reset during RUN SHALL discard the sequence; after release the block accepts a new start.

Structure
REQ-029 Package aes_rcon_pkg SHALL hold the mode enum, per-mode count N and reverse-seed tables, and the constant 0x1b.
REQ-030 One combinational sub-module, rcon_step (8-bit in, dir, 8-bit out), SHALL implement the REQ-019 forward/inverse step.
REQ-031 All outputs SHALL be driven from registers.

Verification
REQ-032 Mode 0, dir 0, out_ready=1: start at T -> words 01..36 at T+1..T+10, out_last at T+10, done at T+11.
REQ-033 Mode 2, dir 1, out_ready=1 -> 40 20 10 08 04 02 01 with idx 6..0, out_last on 01.
REQ-034 Mode 1, dir 0, out_ready toggled 1/0 -> 01 02 04 08 10 20 40 80 with outputs stable while stalled; 8 transfers and 1 done total.
REQ-035 Mode 3 forward and reverse -> REQ-025 sequence and its exact reverse; WORD_W=8 and WORD_W=64 builds place the byte in the MSBs.
REQ-036 abort at idx 3 together with start -> IDLE next cycle, no done, start ignored; rst_n pulse mid-RUN -> outputs zero asynchronously; next start restarts at 0x01.

Source files
------------

// File: rtl/aes_rcon_pkg.sv
// Shared definitions for the AES round-constant generator.
//   - rcon_mode_e  : key-schedule flavour selected by the 2-bit mode input
//   - rcon_state_e : two-state controller encoding (IDLE / RUN)
//   - RCON_POLY    : low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   - rcon_count   : number of constants N emitted per mode
//   - rcon_last_idx: index of the final constant (N-1)
//   - rcon_rev_seed: constant x^(N-1), the first word of a reverse sequence
package aes_rcon_pkg;

  typedef enum logic [1:0] {
    MODE_AES128 = 2'd0,
    MODE_AES192 = 2'd1,
    MODE_AES256 = 2'd2,
    MODE_EXT    = 2'd3
  } rcon_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rcon_state_e;

  localparam logic [7:0] RCON_POLY = 8'h1b;

  function automatic logic [4:0] rcon_count(input rcon_mode_e m);
    logic [4:0] n;
    case (m)
      MODE_AES128: n = 5'd10;
      MODE_AES192: n = 5'd8;
      MODE_AES256: n = 5'd7;
      default:     n = 5'd16;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] rcon_last_idx(input rcon_mode_e m);
    return 4'(rcon_count(m) - 5'd1);
  endfunction

  // Precomputed x^(N-1) so a reverse sequence can start without iterating.
  function automatic logic [7:0] rcon_rev_seed(input rcon_mode_e m);
    logic [7:0] b;
    case (m)
      MODE_AES128: b = 8'h36;
      MODE_AES192: b = 8'h80;
      MODE_AES256: b = 8'h40;
      default:     b = 8'h2f;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rcon_step.sv
// One step of the round-constant recurrence in GF(2^8).
//   b_in  : current constant x^i
//   dir   : 0 = multiply by x (next constant), 1 = divide by x (previous one)
//   b_out : x^(i+1) when dir=0, x^(i-1) when dir=1
module rcon_step
  import aes_rcon_pkg::*;
(
  input  logic [7:0] b_in,
  input  logic       dir,
  output logic [7:0] b_out
);

  logic [7:0] fwd;
  logic [7:0] rev;

  always_comb begin
    fwd = {b_in[6:0], 1'b0} ^ (b_in[7] ? RCON_POLY : 8'h00);
    // Inverse of xtime: an odd byte must have had the reduction applied,
    // so undo it and restore the shifted-out top bit.
    rev = b_in[0] ? (((b_in ^ RCON_POLY) >> 1) | 8'h80) : (b_in >> 1);
    b_out = dir ? rev : fwd;
  end

endmodule

// File: rtl/rcon_gen.sv
// AES round-constant sequence generator with a valid/ready output stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a sequence (accepted only in IDLE, abort low)
//   mode       : 0=AES-128 (10), 1=AES-192 (8), 2=AES-256 (7), 3=extended (16)
//   dir        : 0 = forward from 0x01, 1 = reverse from the last constant
//   abort      : cancel the running sequence at the next edge, no done
//   out_ready  : downstream accepts the current word
//   out_valid  : out_rcon / out_idx / out_last are valid
//   out_rcon   : constant byte in bits [WORD_W-1:WORD_W-8], zeros elsewhere
//   out_idx    : round index i of the constant x^i
//   out_last   : current word is the final one of the sequence
//   busy       : sequence in progress
//   done       : one-cycle pulse after the final transfer
module rcon_gen
  import aes_rcon_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              dir,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_rcon,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  if (WORD_W < 8) begin : g_bad_width
    $error("rcon_gen: WORD_W must be at least 8");
  end

  rcon_state_e state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic [3:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        dir_q, dir_d;
  logic [3:0]  last_idx_q, last_idx_d;

  rcon_mode_e  mode_in;
  logic        accept;
  logic        xfer;
  logic [7:0]  step_out;
  logic [3:0]  idx_nxt;

  rcon_step u_step (
    .b_in  (byte_q),
    .dir   (dir_q),
    .b_out (step_out)
  );

  assign mode_in = rcon_mode_e'(mode);
  assign accept  = (state_q == ST_IDLE) && start && !abort;
  // In RUN the output is always valid, so ready alone marks a transfer.
  assign xfer    = (state_q == ST_RUN) && out_ready && !abort;

  // Next-state logic.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (abort || (xfer && last_q)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; every output comes straight from a flop.
  always_comb begin
    byte_d     = byte_q;
    idx_d      = idx_q;
    last_d     = last_q;
    done_d     = 1'b0;
    dir_d      = dir_q;
    last_idx_d = last_idx_q;
    idx_nxt    = dir_q ? (idx_q - 4'd1) : (idx_q + 4'd1);

    if (abort) begin
      byte_d = 8'h00;
      idx_d  = 4'd0;
      last_d = 1'b0;
    end else if (accept) begin
      dir_d      = dir;
      last_idx_d = rcon_last_idx(mode_in);
      byte_d     = dir ? rcon_rev_seed(mode_in) : 8'h01;
      idx_d      = dir ? rcon_last_idx(mode_in) : 4'd0;
      // A one-word sequence would be last immediately in either direction.
      last_d     = (rcon_last_idx(mode_in) == 4'd0);
    end else if (xfer) begin
      if (last_q) begin
        byte_d = 8'h00;
        idx_d  = 4'd0;
        last_d = 1'b0;
        done_d = 1'b1;
      end else begin
        byte_d = step_out;
        idx_d  = idx_nxt;
        last_d = dir_q ? (idx_nxt == 4'd0) : (idx_nxt == last_idx_q);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q     <= 8'h00;
      idx_q      <= 4'd0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      dir_q      <= 1'b0;
      last_idx_q <= 4'd0;
    end else begin
      byte_q     <= byte_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      done_q     <= done_d;
      dir_q      <= dir_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign out_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign out_rcon  = WORD_W'(byte_q) << (WORD_W - 8);
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rcon_gen.sv
module tb_rcon_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic        dir;
  logic        abort;
  logic        out_ready;

  logic        out_valid, out_last, busy, done;
  logic [31:0] out_rcon;
  logic [3:0]  out_idx;

  logic        v8, l8, b8, d8;
  logic [7:0]  rcon8;
  logic [3:0]  i8;
  logic        v64, l64, b64, d64;
  logic [63:0] rcon64;
  logic [3:0]  i64;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  rcon_gen #(.WORD_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dir(dir),
    .abort(abort), .out_ready(out_ready), .out_valid(out_valid),
    .out_rcon(out_rcon), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done)
  );

  rcon_gen #(.WORD_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dir(dir),
    .abort(abort), .out_ready(out_ready), .out_valid(v8),
    .out_rcon(rcon8), .out_idx(i8), .out_last(l8),
    .busy(b8), .done(d8)
  );

  rcon_gen #(.WORD_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dir(dir),
    .abort(abort), .out_ready(out_ready), .out_valid(v64),
    .out_rcon(rcon64), .out_idx(i64), .out_last(l64),
    .busy(b64), .done(d64)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  // Hand-computed x^i, i = 0..15.
  logic [7:0] seq_ext [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                               8'h40, 8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8,
                               8'hab, 8'h4d, 8'h9a, 8'h2f};

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int n_of(input logic [1:0] m);
    case (m)
      2'd0:    return 10;
      2'd1:    return 8;
      2'd2:    return 7;
      default: return 16;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [7:0] b,
                            input logic [3:0] idx, input logic last);
    check({tag, " valid"},  out_valid, 64'd1);
    check({tag, " rcon"},   out_rcon,  {32'h0, b, 24'h0});
    check({tag, " idx"},    out_idx,   idx);
    check({tag, " last"},   out_last,  last);
    check({tag, " busy"},   busy,      64'd1);
    check({tag, " done"},   done,      64'd0);
    check({tag, " rcon8"},  rcon8,     b);
    check({tag, " rcon64"}, rcon64,    {b, 56'h0});
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, " valid"},  out_valid, 64'd0);
    check({tag, " rcon"},   out_rcon,  64'd0);
    check({tag, " idx"},    out_idx,   64'd0);
    check({tag, " last"},   out_last,  64'd0);
    check({tag, " busy"},   busy,      64'd0);
    check({tag, " done"},   done,      exp_done);
    check({tag, " rcon8"},  rcon8,     64'd0);
    check({tag, " rcon64"}, rcon64,    64'd0);
  endtask

  task automatic run_seq(input logic [1:0] m, input logic d, input bit stall,
                         input string tag);
    int n;
    int sent;
    int budget;
    int dc0;
    int k;
    bit phase;
    n      = n_of(m);
    sent   = 0;
    budget = 100;
    dc0    = done_cnt;
    phase  = 1'b0;
    mode = m; dir = d; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    // Mode/dir changes while running must not disturb the sequence.
    mode = ~m; dir = ~d;
    while (sent < n && budget > 0) begin
      budget--;
      k = d ? (n - 1 - sent) : sent;
      check_word(tag, seq_ext[k], 4'(k), (sent == n - 1));
      if (stall && !phase) begin
        out_ready = 1'b0;
        tick();
        check_word({tag, " stall"}, seq_ext[k], 4'(k), (sent == n - 1));
        out_ready = 1'b1;
      end
      phase = ~phase;
      // Start during the final transfer must be ignored.
      if (sent == n - 1) start = 1'b1;
      tick();
      start = 1'b0;
      sent++;
    end
    check({tag, " transfers"}, sent, n);
    check_idle({tag, " end"}, 1'b1);
    tick();
    check_idle({tag, " after"}, 1'b0);
    check({tag, " done count"}, done_cnt - dc0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; dir = 1'b0;
    abort = 1'b0; out_ready = 1'b1;
    #2;
    check_idle("por", 1'b0);
    #10 rst_n = 1'b1;
    tick();
    check_idle("idle", 1'b0);

    run_seq(2'd0, 1'b0, 1'b0, "m0_fwd");
    run_seq(2'd2, 1'b1, 1'b0, "m2_rev");
    run_seq(2'd1, 1'b0, 1'b1, "m1_stall");
    run_seq(2'd3, 1'b0, 1'b0, "m3_fwd");
    run_seq(2'd3, 1'b1, 1'b0, "m3_rev");

    // Abort at idx 3 with a concurrent start.
    dc0 = done_cnt;
    mode = 2'd0; dir = 1'b0; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("abort pre idx", out_idx, 64'd3);
    check("abort pre rcon", out_rcon, 64'h0800_0000);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check_idle("abort", 1'b0);
    tick();
    check_idle("abort after", 1'b0);
    check("abort done count", done_cnt - dc0, 64'd0);

    // Asynchronous reset in the middle of a run.
    mode = 2'd1; dir = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst pre idx", out_idx, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async rst", 1'b0);
    #3 rst_n = 1'b1;
    tick();
    check_idle("rst release", 1'b0);
    run_seq(2'd0, 1'b0, 1'b0, "restart");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
